// File: rtl/tpu_pkg.sv
// Shared widths, row/word derivation and write-back state encoding.
package tpu_pkg;

    localparam int DEF_ARRAY_SIZE        = 32;
    localparam int DEF_OUTPUT_DATA_WIDTH = 16;
    localparam int DEF_SRAM_DATA_WIDTH   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } qwb_state_e;

    // SRAM words needed to hold one quantized row.
    function automatic int calc_wpr(input int array_size,
                                    input int out_w,
                                    input int sram_w);
        return (array_size * out_w) / sram_w;
    endfunction

endpackage

// File: rtl/quant_writeback_row_fifo.sv
// Synchronous row buffer; extra pointer bit separates full from empty.
module row_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

endmodule

// File: rtl/quant_writeback.sv
// Quantizer write-back: buffers rows and streams them to SRAM one word per cycle.
// Optional QWB_RELU_EN clamps negative elements to zero at the FIFO read side.
module quant_writeback
    import tpu_pkg::*;
#(
    parameter int ARRAY_SIZE        = DEF_ARRAY_SIZE,
    parameter int OUTPUT_DATA_WIDTH = DEF_OUTPUT_DATA_WIDTH,
    parameter int SRAM_DATA_WIDTH   = DEF_SRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH        = 10,
    parameter int ROW_CNT_WIDTH     = 8,
    parameter int FIFO_DEPTH        = 2
) (
    input  logic                                      clk,
    input  logic                                      srst,
    input  logic                                      start,
    input  logic [ADDR_WIDTH-1:0]                     base_addr,
    input  logic [ROW_CNT_WIDTH-1:0]                  num_rows,
    input  logic                                      in_valid,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   in_data,
    output logic                                      in_ready,
    output logic                                      sram_we,
    output logic [ADDR_WIDTH-1:0]                     sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0]                sram_wdata,
    output logic                                      busy,
    output logic                                      done
);

    localparam int ROW_W = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
    localparam int WPR   = calc_wpr(ARRAY_SIZE, OUTPUT_DATA_WIDTH,
                                    SRAM_DATA_WIDTH);
    localparam int KW    = (WPR > 1) ? $clog2(WPR) : 1;

    localparam logic [KW-1:0]            K_LAST  = KW'(WPR - 1);
    localparam logic [KW-1:0]            K_ONE   = KW'(1);
    localparam logic [ROW_CNT_WIDTH-1:0] CNT_ONE = ROW_CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]    A_ONE   = ADDR_WIDTH'(1);

    qwb_state_e               state_q;
    logic [ADDR_WIDTH-1:0]    wr_addr_q;
    logic [ROW_CNT_WIDTH-1:0] num_rows_q;
    logic [ROW_CNT_WIDTH-1:0] acc_cnt_q;
    logic [ROW_CNT_WIDTH-1:0] rows_wr_q;
    logic [KW-1:0]            k_q;
    logic                     sram_we_q;
    logic [ADDR_WIDTH-1:0]    sram_addr_q;
    logic [SRAM_DATA_WIDTH-1:0] sram_wdata_q;
    logic                     busy_q;
    logic                     done_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [ROW_W-1:0] fifo_rdata;
    logic [ROW_W-1:0] src_raw;
    logic [ROW_W-1:0] src_row;
    logic [WPR-1:0][SRAM_DATA_WIDTH-1:0] src_words;
    logic             push;
    logic             wr_en;
    logic             last_word;

    assign in_ready  = (state_q == RUN) && !fifo_full &&
                       (acc_cnt_q < num_rows_q);
    assign push      = in_valid && in_ready;
    assign last_word = (k_q == K_LAST);

    // An empty FIFO forwards the incoming row so its first word issues
    // in the same cycle it is accepted.
    assign src_raw   = fifo_empty ? in_data : fifo_rdata;
    assign wr_en     = (state_q == RUN) && (!fifo_empty || push);
    assign fifo_pop  = wr_en && last_word && !fifo_empty;
    assign fifo_push = push && !(fifo_empty && last_word);

`ifdef QWB_RELU_EN
    always_comb begin
        src_row = src_raw;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            if (src_raw[i*OUTPUT_DATA_WIDTH + OUTPUT_DATA_WIDTH - 1]) begin
                src_row[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] = '0;
            end
        end
    end
`else
    assign src_row = src_raw;
`endif

    assign src_words = src_row;

    row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk_i   (clk),
        .srst_i  (srst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (in_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            num_rows_q   <= '0;
            acc_cnt_q    <= '0;
            rows_wr_q    <= '0;
            k_q          <= '0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            sram_we_q <= 1'b0;
            done_q    <= 1'b0;
            if (push) acc_cnt_q <= acc_cnt_q + CNT_ONE;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        wr_addr_q  <= base_addr;
                        num_rows_q <= num_rows;
                        acc_cnt_q  <= '0;
                        rows_wr_q  <= '0;
                        k_q        <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= (num_rows == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (wr_en) begin
                        sram_we_q    <= 1'b1;
                        sram_addr_q  <= wr_addr_q;
                        sram_wdata_q <= src_words[k_q];
                        wr_addr_q    <= wr_addr_q + A_ONE;
                        if (last_word) begin
                            k_q       <= '0;
                            rows_wr_q <= rows_wr_q + CNT_ONE;
                            if (rows_wr_q == num_rows_q - CNT_ONE) begin
                                state_q <= DONE;
                            end
                        end else begin
                            k_q <= k_q + K_ONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/quant_writeback.md
# quant_writeback

Output write-back stage directly downstream of the quantizer. Accepts one quantized row per handshake: ARRAY_SIZE signed 16-bit results, ARRAY_SIZE*OUTPUT_DATA_WIDTH bits. Buffers rows in a small FIFO, slices each row into SRAM-width words and issues one SRAM write per cycle at consecutive addresses from a programmed base. Reports busy and a one-cycle done pulse when the programmed number of rows has been written.

## Interface
- ARRAY_SIZE, 32, elements per quantized row
- OUTPUT_DATA_WIDTH, 16, bits per quantized element
- SRAM_DATA_WIDTH, 32, SRAM word width; must divide ARRAY_SIZE*OUTPUT_DATA_WIDTH and be a multiple of OUTPUT_DATA_WIDTH
- ADDR_WIDTH, 10, SRAM address width
- ROW_CNT_WIDTH, 8, width of the row-count register
- FIFO_DEPTH, 2, row buffer entries; power of two, at least 2
- clk  in  1  clock; all logic is on the rising edge
- srst  in  1  synchronous reset, active-high
- start  in  1  one-cycle job start; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first SRAM address of the job; latched on start
- num_rows  in  ROW_CNT_WIDTH  rows in the job; latched on start
- in_valid  in  1  quantized row valid
- in_data  in  ARRAY_SIZE*OUTPUT_DATA_WIDTH  quantized row; element i at [i*16 +: 16]
- in_ready  out  1  row accepted when in_valid && in_ready
- sram_we  out  1  SRAM write enable, active-high, registered
- sram_addr  out  ADDR_WIDTH  SRAM write address, registered
- sram_wdata  out  SRAM_DATA_WIDTH  SRAM write data, registered
- busy  out  1  high from the cycle after start until the done cycle
- done  out  1  one-cycle pulse after the job's last write

## Operation
- WPR = ARRAY_SIZE*OUTPUT_DATA_WIDTH/SRAM_DATA_WIDTH words per row. With the defaults, WPR = 16.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start, latch base_addr and num_rows, and clear the row accept counter, the word index k, and the row write counter.
  - If num_rows == 0, go to DONE. Otherwise go to RUN.
  - A start seen in RUN or DONE is ignored.
- RUN, accept side:
  - in_ready = !fifo_full && (rows accepted < num_rows).
  - Rows offered in IDLE, in DONE, or after num_rows rows have been accepted are not accepted; in_ready is low.
- RUN, write side: while the FIFO is non-empty, each cycle writes one word:
  - Data: sram_wdata = head[k*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH].
  - Address: sram_addr = wr_addr, which starts at base_addr and increments once per write.
  - k advances each write. At k == WPR-1, pop the FIFO, clear k and increment the row write counter.
- Address wrap: wr_addr wraps modulo 2^ADDR_WIDTH with no error indication.
- Push and pop in the same cycle are allowed when the FIFO is not full. When the FIFO is full, no push happens that cycle, even if a pop occurs.
- RUN → DONE: when the last word of row num_rows-1 is written.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Element order inside an SRAM word: the lower-index element sits in the lower bits, i.e. a straight slice with no reordering.

## Timing
- Reset values: sram_we 0, sram_addr 0, sram_wdata 0, in_ready 0, busy 0, done 0. State is IDLE; FIFO, counters and latched registers are cleared.
- Reset mid-job aborts immediately. No further writes occur, buffered rows are discarded, and no done pulse is produced.
- start at cycle t gives busy = 1 and RUN at t+1. in_ready can be high at t+1.
- A row accepted at cycle t into an empty FIFO gives its first sram_we at t+1, then WPR consecutive write cycles with no gaps while data is buffered.
- Sustained throughput is one row per WPR cycles.
- done is asserted in the cycle after the final sram_we. busy falls in that same cycle.
- Job latency with rows supplied back-to-back: 1 + num_rows*WPR + 1 cycles from start to done.

## Configuration
- QWB_RELU_EN:
  - When defined, each 16-bit element with its sign bit set is replaced by 0 before slicing. This is applied at the FIFO read side and adds no latency.
  - When undefined, elements pass unchanged and the clamp logic is absent.

## Structure
- Shared package tpu_pkg holds:
  - default widths: ARRAY_SIZE, OUTPUT_DATA_WIDTH, SRAM_DATA_WIDTH;
  - the WPR derivation;
  - the state encoding typedef: IDLE, RUN, DONE.
- One sub-module, row_fifo: synchronous FIFO with parameterized width and depth, push/pop, full/empty, and synchronous clear on srst.

## Test plan
- Single row: base_addr = 0x010, num_rows = 1; row with element i = i.
  - Expect 16 writes to addresses 0x010–0x01F.
  - Word 0 = 0x00010000; word 15 = 0x001F001E.
  - done one cycle after the last write.
- Back-to-back: num_rows = 4 with in_valid held high.
  - Expect 64 gapless writes at 0x000–0x03F.
  - in_ready drops when the FIFO is full and again after the 4th row is accepted.
  - done occurs at cycle 66 after start.
- Wrap: base_addr = 0x3F8, num_rows = 1.
  - Expect addresses 0x3F8–0x3FF, then 0x000–0x007.
- Boundaries:
  - num_rows = 0: done at t+2 with no sram_we.
  - start pulsed during RUN: ignored; base address and row count unchanged.
- srst asserted after 5 writes of a 2-row job:
  - Outputs return to zero the next cycle.
  - No further writes and no done.
  - A new job afterwards runs correctly.
- With QWB_RELU_EN defined, element values 0x8000 and 0x7FFF.
  - Expect 0x0000 and 0x7FFF.
  - Without the macro, expect 0x8000 and 0x7FFF unchanged.
